// File: rtl/param_sram_ctl.sv
// Parametrised 1W/1R SRAM controller: lane mask, RD_LAT 1/2, clear sweep, range check.
// Optional RAM_PARITY_EN adds per-lane even parity with a sticky PERR flag.
module param_sram_ctl #(
  parameter int DW     = 24,
  parameter int AW     = 20,
  parameter int DEPTH  = 65536,
  parameter int LANES  = 3,
  parameter int RD_LAT = 1
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [DW-1:0]    WD,
  input  logic [LANES-1:0] WM,
  input  logic             RE,
  input  logic [AW-1:0]    RA,
  output logic [DW-1:0]    Q,
  output logic             QV,
  output logic             READY,
  output logic             AERR,
  output logic             PERR
);

  localparam int LW = DW / LANES;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [DW-1:0] q_q, q_d;
  logic        qv_q, qv_d;
  logic        aerr_q, aerr_d;
  logic        perr_q, perr_d;

  logic [DW-1:0] mem [DEPTH];

  logic          run, wa_ok, ra_ok, wr_en, byp;
  logic [IW-1:0] wa_idx, ra_idx, mem_idx;
  logic [DW-1:0] wr_old, wr_new, rd_word, mem_wd;
  logic          mem_we;
  logic          rd_vld, rd_err;
  logic          fin_vld, fin_err;
  logic [DW-1:0] fin_data;

  assign run    = (state_q == S_RUN);
  assign wa_ok  = {1'b0, WA} < DEPTH_W;
  assign ra_ok  = {1'b0, RA} < DEPTH_W;
  assign wa_idx = WA[IW-1:0];
  assign ra_idx = RA[IW-1:0];
  assign wr_en  = run & WE & wa_ok;
  assign byp    = wr_en & (WA == RA);
  assign rd_vld = run & RE;
  assign wr_old = mem[wa_idx];

  always_comb begin
    wr_new = wr_old;
    for (int l = 0; l < LANES; l++) begin
      if (WM[l]) wr_new[l*LW +: LW] = WD[l*LW +: LW];
    end
  end

  // write-first: a same-address read sees the merged word
  always_comb begin
    rd_word = '0;
    if (ra_ok) rd_word = byp ? wr_new : mem[ra_idx];
  end

  always_comb begin
    mem_we  = 1'b0;
    mem_idx = wa_idx;
    mem_wd  = wr_new;
    if (RSTN && !run) begin
      mem_we  = 1'b1;
      mem_idx = cnt_q[IW-1:0];
      mem_wd  = '0;
    end else if (RSTN && wr_en) begin
      mem_we  = 1'b1;
    end
  end

  always_ff @(posedge CK) begin
    if (mem_we) mem[mem_idx] <= mem_wd;
  end

`ifdef RAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] wr_par, mem_wp, rd_par, rd_calc;

  always_comb begin
    wr_par = par_mem[wa_idx];
    for (int l = 0; l < LANES; l++) begin
      if (WM[l]) wr_par[l] = ^WD[l*LW +: LW];
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rd_calc[l] = ^rd_word[l*LW +: LW];
    end
  end

  assign mem_wp = run ? wr_par : '0;
  assign rd_par = byp ? wr_par : par_mem[ra_idx];
  assign rd_err = ra_ok & (|(rd_calc ^ rd_par));

  always_ff @(posedge CK) begin
    if (mem_we) par_mem[mem_idx] <= mem_wp;
  end
`else
  assign rd_err = 1'b0;
`endif

  if (RD_LAT == 2) begin : g_lat2
    logic          p1_vld_q, p1_err_q;
    logic [DW-1:0] p1_data_q;
    always_ff @(posedge CK) begin
      if (!RSTN) begin
        p1_vld_q  <= 1'b0;
        p1_err_q  <= 1'b0;
        p1_data_q <= '0;
      end else begin
        p1_vld_q  <= rd_vld;
        p1_err_q  <= rd_err;
        p1_data_q <= rd_word;
      end
    end
    assign fin_vld  = p1_vld_q;
    assign fin_err  = p1_err_q;
    assign fin_data = p1_data_q;
  end else begin : g_lat1
    assign fin_vld  = rd_vld;
    assign fin_err  = rd_err;
    assign fin_data = rd_word;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_W) state_d = S_RUN;
    end
    aerr_d = aerr_q | (run & ((WE & !wa_ok) | (RE & !ra_ok)));
    qv_d   = fin_vld;
    q_d    = fin_vld ? fin_data : q_q;
    perr_d = perr_q | (fin_vld & fin_err);
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      aerr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      aerr_q  <= aerr_d;
      perr_q  <= perr_d;
    end
  end

  assign Q     = q_q;
  assign QV    = qv_q;
  assign READY = run;
  assign AERR  = aerr_q;
  assign PERR  = perr_q;

endmodule

// File: tb/tb_param_sram_ctl.sv
// Bench for param_sram_ctl: RD_LAT=1 and RD_LAT=2 instances on shared stimulus.
// Scoreboard queues hold expected read data and the cycle it must appear.
module tb_param_sram_ctl;

  localparam int DW    = 24;
  localparam int AW    = 20;
  localparam int DEPTH = 16;
  localparam int LANES = 3;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn, we, re;
  logic [AW-1:0]    wa, ra;
  logic [DW-1:0]    wd;
  logic [LANES-1:0] wm;

  logic [DW-1:0] q1, q2;
  logic qv1, qv2, rdy1, rdy2, aerr1, aerr2, perr1, perr2;

  param_sram_ctl #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .LANES(LANES), .RD_LAT(1)
  ) dut1 (
    .CK(clk), .RSTN(rstn), .WE(we), .WA(wa), .WD(wd), .WM(wm),
    .RE(re), .RA(ra), .Q(q1), .QV(qv1), .READY(rdy1),
    .AERR(aerr1), .PERR(perr1)
  );

  param_sram_ctl #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .LANES(LANES), .RD_LAT(2)
  ) dut2 (
    .CK(clk), .RSTN(rstn), .WE(we), .WA(wa), .WD(wd), .WM(wm),
    .RE(re), .RA(ra), .Q(q2), .QV(qv2), .READY(rdy2),
    .AERR(aerr2), .PERR(perr2)
  );

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_en = 1'b0;
  sb_t sb1[$];
  sb_t sb2[$];
  logic [DW-1:0] mdl [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] d,
                                          input logic [LANES-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < LANES; l++) begin
      if (m[l]) r[l*8 +: 8] = d[l*8 +: 8];
    end
    return r;
  endfunction

  task automatic mon(input int k, input logic qv, input logic [DW-1:0] q);
    sb_t e;
    int  sz;
    sz = (k == 0) ? sb1.size() : sb2.size();
    if (qv === 1'b1) begin
      n_cmp++;
      assert (sz > 0) else begin
        n_bad++;
        $error("FAIL qv_unexpected dut%0d observed=1 expected=0", k + 1);
      end
      if (sz > 0) begin
        if (k == 0) e = sb1.pop_front();
        else e = sb2.pop_front();
        chk($sformatf("q_dut%0d", k + 1), {8'h0, q}, {8'h0, e.data});
        chk($sformatf("qv_cycle_dut%0d", k + 1), cyc, e.due);
      end
    end else if (sz > 0) begin
      if (k == 0) e = sb1[0];
      else e = sb2[0];
      if (e.due <= cyc) begin
        chk($sformatf("qv_missing_dut%0d", k + 1), {31'b0, qv}, 32'd1);
        if (k == 0) void'(sb1.pop_front());
        else void'(sb2.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, qv1, q1);
      mon(1, qv2, q2);
    end
  end

  task automatic op(input logic w, input int a_w, input logic [DW-1:0] d,
                    input logic [LANES-1:0] m, input logic r, input int a_r);
    logic [DW-1:0] mg, e;
    sb_t s;
    we = w;
    wa = a_w[AW-1:0];
    wd = d;
    wm = m;
    re = r;
    ra = a_r[AW-1:0];
    mg = '0;
    e  = '0;
    if (a_w < DEPTH) mg = merge(mdl[a_w[3:0]], d, m);
    if (a_r < DEPTH) begin
      if (w && a_w == a_r) e = mg;
      else e = mdl[a_r[3:0]];
    end
    if (w && a_w < DEPTH) mdl[a_w[3:0]] = mg;
    @(posedge clk);
    #1;
    if (r) begin
      s.data = e;
      s.due  = cyc;
      sb1.push_back(s);
      s.due  = cyc + 1;
      sb2.push_back(s);
    end
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    we = 1'b0; re = 1'b0;
    wa = '0; ra = '0; wd = '0; wm = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_q",    {8'h0, q1},  32'h0);
    chk("rst_q2",   {8'h0, q2},  32'h0);
    chk("rst_flags1", {28'h0, qv1, rdy1, aerr1, perr1}, 32'h0);
    chk("rst_flags2", {28'h0, qv2, rdy2, aerr2, perr2}, 32'h0);
    mon_en = 1'b1;

    // requests held active through CLEAR must be ignored
    we = 1'b1; wa = 20'd9; wd = 24'hFFFFFF; wm = 3'b111;
    re = 1'b1; ra = 20'd9;
    rstn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
      chk("ready_pre", {30'h0, rdy1, rdy2}, 32'h0);
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_midrst", {30'h0, rdy1, rdy2}, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ready_sweep%0d", i), {30'h0, rdy1, rdy2},
          (i == DEPTH) ? 32'h3 : 32'h0);
    end
    we = 1'b0;
    re = 1'b0;

    op(0, 0, 24'h0, 3'b000, 1, 9);
    op(1, 5, 24'hABCDEF, 3'b111, 0, 0);
    op(0, 0, 24'h0, 3'b000, 1, 5);
    op(1, 5, 24'h123456, 3'b010, 0, 0);
    op(0, 0, 24'h0, 3'b000, 1, 5);
    chk("mdl_mask", {8'h0, mdl[5]}, 32'h00AB34EF);
    op(1, 7, 24'h111111, 3'b101, 1, 7);
    chk("mdl_same", {8'h0, mdl[7]}, 32'h00110011);
    op(0, 0, 24'h0, 3'b000, 1, 5);
    op(0, 0, 24'h0, 3'b000, 1, 7);
    idle();

    chk("aerr_pre", {30'h0, aerr1, aerr2}, 32'h0);
    op(1, 20, 24'hFFFFFF, 3'b111, 0, 0);
    chk("aerr_wr", {30'h0, aerr1, aerr2}, 32'h3);
    op(0, 0, 24'h0, 3'b000, 1, 20);
    op(1, 2, 24'h0A0B0C, 3'b111, 1, 3);
    op(0, 0, 24'h0, 3'b000, 1, 2);
    op(1, 5, 24'hFFFFFF, 3'b000, 0, 0);
    for (int a = 0; a < DEPTH; a++) op(0, 0, 24'h0, 3'b000, 1, a);
    idle();

    for (int i = 0; i < 60; i++) begin
      op(1'($urandom_range(0, 1)), int'($urandom_range(0, 19)),
         24'($urandom), 3'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)), int'($urandom_range(0, 19)));
    end
    idle();

`ifdef RAM_PARITY_EN
    chk("perr_pre", {30'h0, perr1, perr2}, 32'h0);
    dut1.par_mem[3] = dut1.par_mem[3] ^ 3'b001;
    dut2.par_mem[3] = dut2.par_mem[3] ^ 3'b001;
    op(0, 0, 24'h0, 3'b000, 1, 3);
    chk("perr_dut1", {30'h0, perr1, qv1}, 32'h3);
    idle();
    chk("perr_dut2", {30'h0, perr2, qv2}, 32'h3);
`else
    chk("perr_off", {30'h0, perr1, perr2}, 32'h0);
`endif

    repeat (4) idle();
    chk("sb_drain1", sb1.size(), 32'h0);
    chk("sb_drain2", sb2.size(), 32'h0);
    chk("aerr_sticky", {30'h0, aerr1, aerr2}, 32'h3);
    chk("ready_hold", {30'h0, rdy1, rdy2}, 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
